// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and receiver state type
package spi_pkg;

    // Word width shared with the 12-bit SPI master
    localparam int SPI_DATA_W      = 12;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_rx_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop pin synchronizer with edge pulses
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    // Shift the asynchronous pin through the chain; r_dly holds the previous synced level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    // Edges are relative to a chain that resets low, so a pin already low is never a fall
    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_dly;
    assign o_fall  = r_dly & ~r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampling mode-0 SPI receiver with valid/ready output
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W);

    logic          w_cs_s;
    logic          w_cs_rise;
    logic          w_cs_fall;
    logic          w_sclk_s;
    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_mosi_s;
    logic          w_mosi_rise;
    logic          w_mosi_fall;
    logic          w_unused;
    logic [DATA_W-1:0] w_word;
    logic          w_take_bit;
    logic          w_last_bit;

    spi_rx_state_t     r_state;
    logic [DATA_W-1:0] r_shift_reg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_frame_err;
    logic              r_overrun;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (cs),
        .o_level (w_cs_s),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (sclk),
        .o_level (w_sclk_s),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (mosi),
        .o_level (w_mosi_s),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    // Only the synced data level matters; the other edge outputs are intentionally dropped
    assign w_unused = &{1'b0, w_sclk_s, w_sclk_fall, w_mosi_rise, w_mosi_fall};

    // mosi and sclk pass through identical chains, so mosi_s is aligned with sclk_rise
    assign w_word     = {r_shift_reg[DATA_W-2:0], w_mosi_s};
    assign w_take_bit = w_sclk_rise & ~w_cs_s & ~w_cs_rise;
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));

    // Frame FSM, deserializer and output holding register with one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift_reg  <= '0;
            r_bit_cnt    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer handshake; a word completing this cycle overrides the clear below
            if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt   <= '0;
                        r_shift_reg <= '0;
                        r_state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Chip select closing the frame wins over a coincident sclk edge
                    if (w_cs_rise) begin
                        r_frame_err <= 1'b1;
                        r_shift_reg <= '0;
                        r_bit_cnt   <= '0;
                        r_state     <= IDLE;
                    end else if (w_take_bit) begin
                        r_shift_reg <= w_word;
                        if (w_last_bit) begin
                            r_state <= DONE;
                            if (!r_dout_valid || dout_ready) begin
                                r_dout       <= w_word;
                                r_dout_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                DONE: begin
                    // Surplus sclk edges after a full word are silently ignored
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int vecs = 0;
    int errs = 0;

    int          valid_cycles = 0;
    int          valid_rises = 0;
    int          valid_falls = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [11:0] last_dout = '0;

    spi_slave_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Event monitor sampling away from the active edge
    always @(negedge clk) begin
        if (dout_valid) begin
            valid_cycles = valid_cycles + 1;
            last_dout = dout;
        end
        if (dout_valid && !prev_valid) valid_rises = valid_rises + 1;
        if (!dout_valid && prev_valid) valid_falls = valid_falls + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
        prev_valid = dout_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs = vecs + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cs frame of n bits (MSB first); sclk period 80 ns
    task automatic spi_frame(input logic [15:0] bits, input int n, input bit pulse_ready);
        @(posedge clk); #2;
        cs = 1'b0;
        #40;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #40;
            sclk = 1'b1;
            if (pulse_ready && i == 0) begin
                fork
                    begin
                        repeat (2) @(posedge clk);
                        #1 dout_ready = 1'b1;
                        @(posedge clk);
                        #1 dout_ready = 1'b0;
                    end
                join_none
            end
            #40;
            sclk = 1'b0;
        end
        #40;
        cs = 1'b1;
        mosi = 1'b0;
        #160;
    endtask

    task automatic consume_one();
        @(posedge clk); #2 dout_ready = 1'b1;
        @(posedge clk); #2 dout_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (dout !== 12'h000) begin errs++; $display("FAIL reset_dout: got %0h expected 0", dout); end
        vecs++;
        if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0b expected 0", dout_valid); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vecs++;
        if ({frame_err, overrun} !== 2'b00) begin errs++; $display("FAIL reset_flags: got %0b expected 00", {frame_err, overrun}); end
        vecs++;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_nominal();
        int vc0, fe0, ov0;
        dout_ready = 1'b1;
        vc0 = valid_cycles; fe0 = ferr_cnt; ov0 = ovr_cnt;
        spi_frame({4'h0, 12'hA5A}, 12, 1'b0);
        chk("nom_valid_cycles", valid_cycles - vc0, 1);
        chk("nom_dout", last_dout, 12'hA5A);
        chk("nom_ferr", ferr_cnt - fe0, 0);
        chk("nom_ovr", ovr_cnt - ov0, 0);
        chk("nom_busy_after", busy, 0);
    endtask

    task automatic test_backpressure();
        int vr0, ov0;
        dout_ready = 1'b0;
        vr0 = valid_rises; ov0 = ovr_cnt;
        spi_frame({4'h0, 12'hA5A}, 12, 1'b0);
        spi_frame({4'h0, 12'h3C3}, 12, 1'b0);
        chk("bp_dout_held", dout, 12'hA5A);
        chk("bp_valid_held", dout_valid, 1);
        chk("bp_ovr_once", ovr_cnt - ov0, 1);
        chk("bp_valid_rises", valid_rises - vr0, 1);
        consume_one();
        chk("bp_valid_drop", dout_valid, 0);
    endtask

    task automatic test_simultaneous();
        int vf0, ov0;
        dout_ready = 1'b0;
        spi_frame({4'h0, 12'hA5A}, 12, 1'b0);
        chk("sim_first_dout", dout, 12'hA5A);
        vf0 = valid_falls; ov0 = ovr_cnt;
        spi_frame({4'h0, 12'h3C3}, 12, 1'b1);
        chk("sim_dout", dout, 12'h3C3);
        chk("sim_valid", dout_valid, 1);
        chk("sim_no_gap", valid_falls - vf0, 0);
        chk("sim_no_ovr", ovr_cnt - ov0, 0);
        consume_one();
        chk("sim_valid_drop", dout_valid, 0);
        dout_ready = 1'b1;
    endtask

    task automatic test_short_frame();
        int vc0, fe0;
        dout_ready = 1'b1;
        vc0 = valid_cycles; fe0 = ferr_cnt;
        spi_frame({11'h0, 5'b10110}, 5, 1'b0);
        chk("short_ferr", ferr_cnt - fe0, 1);
        chk("short_no_valid", valid_cycles - vc0, 0);
        spi_frame({4'h0, 12'h3C3}, 12, 1'b0);
        chk("short_next_dout", last_dout, 12'h3C3);
        chk("short_next_valid", valid_cycles - vc0, 1);
        chk("short_ferr_total", ferr_cnt - fe0, 1);
    endtask

    task automatic test_extra_clocks();
        int vc0, fe0, ov0;
        dout_ready = 1'b1;
        vc0 = valid_cycles; fe0 = ferr_cnt; ov0 = ovr_cnt;
        spi_frame({2'b00, 12'h801, 2'b11}, 14, 1'b0);
        chk("extra_dout", last_dout, 12'h801);
        chk("extra_valid", valid_cycles - vc0, 1);
        chk("extra_ferr", ferr_cnt - fe0, 0);
        chk("extra_ovr", ovr_cnt - ov0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int vc0, fe0;
        dout_ready = 1'b0;
        @(posedge clk); #2;
        cs = 1'b0;
        #40;
        for (int i = 0; i < 6; i++) begin
            mosi = i[0]; #40; sclk = 1'b1; #40; sclk = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rmf_dout", dout, 12'h000);
        chk("rmf_valid", dout_valid, 0);
        chk("rmf_busy", busy, 0);
        chk("rmf_flags", {frame_err, overrun}, 0);
        vc0 = valid_cycles; fe0 = ferr_cnt;
        for (int i = 0; i < 12; i++) begin
            mosi = 1'b1; #40; sclk = 1'b1; #40; sclk = 1'b0;
        end
        chk("rmf_busy_cs_low", busy, 0);
        #40 cs = 1'b1; mosi = 1'b0;
        #160;
        chk("rmf_no_capture", valid_cycles - vc0, 0);
        chk("rmf_no_ferr", ferr_cnt - fe0, 0);
        dout_ready = 1'b1;
        spi_frame({4'h0, 12'hFFF}, 12, 1'b0);
        chk("rmf_next_dout", last_dout, 12'hFFF);
        chk("rmf_next_valid", valid_cycles - vc0, 1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_simultaneous();
        test_short_frame();
        test_extra_clocks();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI receiver that sits directly downstream of the team's 12-bit SPI master (`spi`) and consumes its cs/sclk/mosi pins.
- Oversamples the SPI pins in the system clock domain and deserializes one MSB-first word per chip-select frame, sampling in mode 0 (rising sclk).
- Presents each received word on a valid/ready parallel interface, with frame-error and overrun flags.

Parameters:
- DATA_W, 12, bits per frame; must equal the master's word width.
- SYNC_STAGES, 2, synchronizer flops on cs/sclk/mosi (minimum 2).

Ports:
- clk  input  1  system clock; sclk high and low phases each >= 2 clk periods.
- rst_n  input  1  synchronous reset, active-low.
- cs  input  1  chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, idle low, asynchronous to clk.
- mosi  input  1  serial data, MSB first, stable around rising sclk.
- dout  output  DATA_W  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  frame in progress (SHIFT or DONE).
- frame_err  output  1  one-cycle pulse: cs deasserted before DATA_W bits.
- overrun  output  1  one-cycle pulse: word completed while holding register full and not being read.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All sync flops go to 0; shift_reg and bit_cnt clear; state goes to IDLE.
  - All outputs go to 0.
  - Reset mid-frame abandons the frame; no frame_err is raised.
- Sync:
  - cs, sclk and mosi each pass through SYNC_STAGES flops, giving cs_s, sclk_s and mosi_s.
  - One extra flop each for cs_d and sclk_d.
  - sclk_rise = sclk_s & ~sclk_d; cs_fall = cs_d & ~cs_s; cs_rise = cs_s & ~cs_d.
  - Because the chain resets to 0, cs already low at reset release is not a fall, so no frame starts until cs goes high then low.
- States: IDLE, SHIFT, DONE.
  - IDLE: on cs_fall, clear bit_cnt and shift_reg and go to SHIFT. sclk edges are ignored.
  - SHIFT, sclk_rise with cs_s low: shift_reg <= {shift_reg[DATA_W-2:0], mosi_s}; bit_cnt++.
  - SHIFT, when bit_cnt == DATA_W-1 on that sclk_rise: the word completes and the state goes to DONE.
  - SHIFT, cs_rise before the word completes: pulse frame_err, discard partial data, go to IDLE.
  - DONE: further sclk edges are ignored and produce no error. On cs_rise, go to IDLE.
  - cs_rise and sclk_rise in the same cycle in SHIFT: cs_rise wins, so the bit is not taken.
- Completion and handshake:
  - Completed word = {shift_reg[DATA_W-2:0], mosi_s}.
  - If dout_valid == 0, or dout_valid && dout_ready: load dout, set dout_valid.
  - Otherwise: keep old dout, drop the new word, pulse overrun.
  - dout_valid clears on dout_valid && dout_ready when no word completes in that cycle.
  - dout is stable while dout_valid == 1.
- Latency: dout_valid rises on the (SYNC_STAGES+2)-th clk rising edge after the final sclk pin rising edge, worst case; the bench accepts edges SYNC_STAGES+1 through SYNC_STAGES+2.
- Bit counter width: $clog2(DATA_W); it never wraps within a frame, because DONE blocks further shifting.
- busy = (state != IDLE).

Decomposition:
- Shared package spi_pkg:
  - SPI_DATA_W = 12, shared with the master.
  - State enum spi_rx_state_t {IDLE, SHIFT, DONE}.
- Sub-module spi_pin_sync:
  - Parameterized depth; one instance per pin.
  - Outputs the synchronized level plus rise/fall pulses.
  - Resets to 0.

Test Plan:
- Nominal: clk 10 ns, sclk 80 ns period, frame 12'hA5A, dout_ready=1 -> exactly one dout_valid cycle with dout=12'hA5A; frame_err=0, overrun=0; busy low after cs rises.
- Backpressure: frames 12'hA5A then 12'h3C3 with dout_ready=0 -> dout stays 12'hA5A and dout_valid stays 1; overrun pulses once. Then dout_ready=1 for one cycle -> dout_valid falls.
- Simultaneous: dout_ready=1 in the exact completion cycle of 12'h3C3 while 12'hA5A is held -> dout becomes 12'h3C3, dout_valid stays 1, no overrun.
- Short frame: cs rises after 5 sclk edges -> one frame_err pulse, no dout_valid. Next full frame 12'h3C3 -> dout=12'h3C3.
- Extra clocks: 14 sclk edges carrying 12'h801 followed by bits 1,1 -> dout=12'h801, no error, single dout_valid.
- Reset mid-frame: rst_n low for 2 clk after 6 bits, cs held low through release -> all outputs 0 and no capture until cs rises. Next frame 12'hFFF -> dout=12'hFFF.
